// File: rtl/spi_exec_debug_master.sv
// spi_exec_debug_master: two-frame SPI mode-0 read-back of a selected exec-stage field (start/sel in, valid/data out, sclk/mosi/ss_n/miso pins)
module spi_exec_debug_master #(
  parameter int NB_BITS = 32,
  parameter int CLK_DIV = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [1:0]         i_sel,
  output logic               o_busy,
  output logic               o_valid,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_sclk,
  output logic               o_mosi,
  output logic               o_ss_n,
  input  logic               i_miso
);
  localparam int BW = $clog2(NB_BITS) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB_BITS - 1);
  typedef enum logic [2:0] {IDLE, FRAME_A, GAP, FRAME_B, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [1:0] sel_q, sel_in;
  logic [NB_BITS-1:0] tx, rx, req;
  logic sclk, in_frame, tick, rise, fall, frame_end, gap_end, accept;
  assign in_frame  = state == FRAME_A || state == FRAME_B;
  assign tick      = in_frame && div_cnt == DIV_LAST;
  assign rise      = tick && !sclk;
  assign fall      = tick && sclk;
  assign frame_end = fall && bit_cnt == BIT_LAST;
  assign gap_end   = state == GAP && div_cnt == DIV_LAST;
  assign accept    = state == IDLE && i_start;
  assign sel_in    = state == IDLE ? i_sel : sel_q;
  always_comb begin
    req = '0;
    req[17:16] = sel_in;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = i_start ? FRAME_A : IDLE;
      FRAME_A: state_n = frame_end ? GAP : FRAME_A;
      GAP:     state_n = gap_end ? FRAME_B : GAP;
      FRAME_B: state_n = frame_end ? DONE : FRAME_B;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) state <= i_reset ? IDLE : state_n;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sel_q   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      o_data  <= '0;
    end else begin
      sel_q   <= accept ? i_sel : sel_q;
      div_cnt <= (tick || gap_end || !(in_frame || state == GAP)) ? '0 : div_cnt + 1'b1;
      bit_cnt <= frame_end ? '0 : fall ? bit_cnt + 1'b1 : bit_cnt;
      sclk    <= tick ? ~sclk : sclk;
      tx      <= (accept || gap_end) ? req : fall ? {tx[NB_BITS-2:0], 1'b0} : tx;
      rx      <= rise ? {rx[NB_BITS-2:0], i_miso} : rx;
      o_data  <= (state == FRAME_B && frame_end) ? rx : o_data;
    end
  end
  assign o_busy  = in_frame || state == GAP;
  assign o_valid = state == DONE;
  assign o_sclk  = sclk;
  assign o_ss_n  = !in_frame;
  assign o_mosi  = in_frame && tx[NB_BITS-1];
endmodule

// File: tb/tb_spi_exec_debug_master.sv
// tb_spi_exec_debug_master: directed table plus corner sequences against a mode-0 slave model
module tb_spi_exec_debug_master;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic start0 = 0, busy0, valid0, sclk0, mosi0, ss_n0, miso0 = 0;
  logic [1:0] sel0 = 0;
  logic [31:0] data0;
  logic start1 = 0, busy1, valid1, sclk1, mosi1, ss_n1, miso1;
  logic [1:0] sel1 = 0;
  logic [31:0] data1;
  spi_exec_debug_master #(.NB_BITS(32), .CLK_DIV(2)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_start(start0), .i_sel(sel0), .o_busy(busy0),
    .o_valid(valid0), .o_data(data0), .o_sclk(sclk0), .o_mosi(mosi0), .o_ss_n(ss_n0), .i_miso(miso0));
  spi_exec_debug_master #(.NB_BITS(32), .CLK_DIV(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(start1), .i_sel(sel1), .o_busy(busy1),
    .o_valid(valid1), .o_data(data1), .o_sclk(sclk1), .o_mosi(mosi1), .o_ss_n(ss_n1), .i_miso(miso1));
  int passed = 0, total = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [31:0] field(input logic [1:0] s);
    return s == 2'd0 ? 32'hDEADBEEF : s == 2'd1 ? 32'h12345678 : s == 2'd2 ? 32'h5 : 32'h0;
  endfunction
  logic [31:0] s_rx, s_tx, s_last = 32'hCAFEF00D;
  logic s_has = 0, p_ss = 1, p_sclk = 0;
  int s_rises;
  logic [31:0] fr_word[$];
  int fr_rise[$];
  always @(ss_n0 or sclk0) begin
    if (ss_n0 === 1'b0 && p_ss === 1'b1) begin
      s_tx = s_has ? field(s_last[17:16]) : s_last;
      miso0 = s_tx[31];
      s_rx = 0;
      s_rises = 0;
    end else if (ss_n0 === 1'b0 && p_sclk === 1'b0 && sclk0 === 1'b1) begin
      s_rx = {s_rx[30:0], mosi0};
      s_rises++;
    end else if (ss_n0 === 1'b0 && p_sclk === 1'b1 && sclk0 === 1'b0) begin
      s_tx = s_tx << 1;
      miso0 = s_tx[31];
    end
    if (ss_n0 === 1'b1 && p_ss === 1'b0) begin
      fr_word.push_back(s_rx);
      fr_rise.push_back(s_rises);
      s_last = s_rx;
      s_has = 1;
    end
    p_ss = ss_n0;
    p_sclk = sclk0;
  end
  logic fr1 = 0;
  always @(negedge ss_n1 or posedge rst) fr1 <= rst ? 1'b0 : ~fr1;
  assign miso1 = fr1;
  int vcyc, nval, gap;
  logic [31:0] vdata;
  task automatic txn0(input logic [1:0] s, input int pulse_at, input logic [1:0] s2);
    fr_word.delete();
    fr_rise.delete();
    vcyc = -1;
    nval = 0;
    gap = 0;
    vdata = 'x;
    @(negedge clk);
    sel0 = s;
    start0 = 1;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start0 = (c == pulse_at);
      sel0 = (c == pulse_at) ? s2 : s;
      if (valid0) begin
        nval++;
        if (vcyc < 0) begin
          vcyc = c;
          vdata = data0;
        end
      end
      if (busy0 && ss_n0) gap++;
    end
  endtask
  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic [31:0] word;
  } vec_t;
  initial begin
    vec_t vec[4];
    int v1a, v1b, n1;
    logic b131, b132;
    vec[0] = '{2'd0, 32'hDEADBEEF, 32'h00000000};
    vec[1] = '{2'd1, 32'h12345678, 32'h00010000};
    vec[2] = '{2'd2, 32'h00000005, 32'h00020000};
    vec[3] = '{2'd3, 32'h00000000, 32'h00030000};
    rst = 1;
    start0 = 1;
    sel0 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    start0 = 0;
    check("rst_ss_n", 32'(ss_n0), 1);
    check("rst_sclk", 32'(sclk0), 0);
    check("rst_mosi", 32'(mosi0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_valid", 32'(valid0), 0);
    check("rst_data", data0, 0);
    @(negedge clk);
    check("rst_prio_busy", 32'(busy0), 0);
    for (int i = 0; i < 4; i++) begin
      txn0(vec[i].sel, 0, 2'd0);
      check($sformatf("v%0d_valid_cycle", i), 32'(vcyc), 259);
      check($sformatf("v%0d_valid_count", i), 32'(nval), 1);
      check($sformatf("v%0d_data", i), vdata, vec[i].data);
      check($sformatf("v%0d_data_hold", i), data0, vec[i].data);
      check($sformatf("v%0d_frames", i), 32'(fr_word.size()), 2);
      check($sformatf("v%0d_mosi_a", i), fr_word.size() > 0 ? fr_word[0] : 'x, vec[i].word);
      check($sformatf("v%0d_mosi_b", i), fr_word.size() > 1 ? fr_word[1] : 'x, vec[i].word);
      check($sformatf("v%0d_rises_a", i), fr_rise.size() > 0 ? 32'(fr_rise[0]) : 'x, 32);
      check($sformatf("v%0d_rises_b", i), fr_rise.size() > 1 ? 32'(fr_rise[1]) : 'x, 32);
      check($sformatf("v%0d_gap", i), 32'(gap), 2);
    end
    txn0(2'd0, 50, 2'd2);
    check("repulse_valid_cycle", 32'(vcyc), 259);
    check("repulse_valid_count", 32'(nval), 1);
    check("repulse_data", vdata, 32'hDEADBEEF);
    check("repulse_mosi_b", fr_word.size() > 1 ? fr_word[1] : 'x, 32'h0);
    @(negedge clk);
    sel0 = 1;
    start0 = 1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start0 = 0;
      if (c == 100) begin
        check("midrst_busy_before", 32'(busy0), 1);
        rst = 1;
      end
    end
    @(negedge clk);
    rst = 0;
    check("midrst_ss_n", 32'(ss_n0), 1);
    check("midrst_busy", 32'(busy0), 0);
    check("midrst_sclk", 32'(sclk0), 0);
    check("midrst_mosi", 32'(mosi0), 0);
    check("midrst_data", data0, 0);
    nval = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid0) nval++;
    end
    check("midrst_no_valid", 32'(nval), 0);
    check("midrst_data_after", data0, 0);
    @(negedge clk);
    sel1 = 3;
    start1 = 1;
    @(posedge clk);
    v1a = -1;
    v1b = -1;
    n1 = 0;
    b131 = 1'bx;
    b132 = 1'bx;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (valid1) begin
        n1++;
        check($sformatf("div1_data_%0d", n1), data1, 0);
        if (v1a < 0) v1a = c;
        else if (v1b < 0) v1b = c;
      end
      if (c == 131) b131 = busy1;
      if (c == 132) b132 = busy1;
      if (v1b > 0) start1 = 0;
    end
    check("div1_first_valid", 32'(v1a), 130);
    check("div1_second_valid", 32'(v1b), 261);
    check("div1_valid_count", 32'(n1), 2);
    check("div1_idle_busy", 32'(b131), 0);
    check("div1_rearm_busy", 32'(b132), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
